lfsr_gf_counter: RTL and testbench

Parametrised, registered block counter for the Romulus tweakey schedule, successor to the single-step combinational GF(2^56) LFSR. Holds the LFSR state, supports init-to-1, arbitrary load and multi-step advance with a ready/done handshake, and flags period wrap. Output is the byte-reversed counter concatenated with an 8-bit domain separator, ready to feed the tweakey register.

---
 rtl/lfsr_gf_pkg.sv | 25 ++
 rtl/lfsr_gf_step.sv | 13 +
 rtl/lfsr_gf_counter.sv | 106 ++++++++++
 tb/tb_lfsr_gf_counter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/lfsr_gf_pkg.sv
// Shared constants, FSM state type and byte-reverse helper for the GF(2^W) block counter.
package lfsr_gf_pkg;

  localparam logic [55:0] POLY56 = 56'h95;
  localparam logic [23:0] POLY24 = 24'h1B;

  // Widest LFSR the byte-reverse helper supports (W must stay below this).
  localparam int unsigned MAXW = 256;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Reverse the byte order of the low w bits of x; the result sits in the low w bits.
  function automatic logic [MAXW-1:0] byte_rev(input logic [MAXW-1:0] x, input int unsigned w);
    logic [MAXW-1:0] full;
    full = '0;
    for (int k = 0; k < int'(MAXW / 8); k++) begin
      full[8*k +: 8] = x[MAXW - 8 - 8*k +: 8];
    end
    return full >> (MAXW - w);
  endfunction

endpackage

// File: rtl/lfsr_gf_step.sv
// Single-step Galois LFSR next-state: shift left, fold the MSB back into the tap mask.
module lfsr_gf_step #(
  parameter int unsigned W    = 56,
  parameter logic [W-1:0] POLY = W'(56'h95)
) (
  input  logic [W-1:0] s,
  output logic [W-1:0] nxt
);

  // Combinational feedback
  assign nxt = {s[W-2:0], 1'b0} ^ (s[W-1] ? POLY : '0);

endmodule

// File: rtl/lfsr_gf_counter.sv
// Registered multi-step LFSR block counter with ready/done handshake and sticky wrap flag.
module lfsr_gf_counter
  import lfsr_gf_pkg::*;
#(
  parameter int unsigned W    = 56,
  parameter logic [W-1:0] POLY = W'(POLY56),
  parameter int unsigned CW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init,
  input  logic          load,
  input  logic [W-1:0]  si,
  input  logic [7:0]    domain,
  input  logic          step,
  input  logic [CW-1:0] nsteps,
  output logic [W+7:0]  so,
  output logic          ready,
  output logic          done,
  output logic          wrap
);

  logic [W-1:0]    st;
  logic [W-1:0]    nxt;
  logic [7:0]      dom;
  logic [CW-1:0]   rem;
  state_t          fsm;
  logic [MAXW-1:0] si_rev_full;
  logic [MAXW-1:0] so_rev_full;
  logic [W-1:0]    si_rev;
  logic            unused_rev;

  lfsr_gf_step #(
    .W    (W),
    .POLY (POLY)
  ) u_step (
    .s   (st),
    .nxt (nxt)
  );

  // Byte-order conversion between the external counter field and internal state
  assign si_rev_full = byte_rev(MAXW'(si), W);
  assign so_rev_full = byte_rev(MAXW'(st), W);
  assign si_rev      = si_rev_full[W-1:0];
  assign unused_rev  = ^{si_rev_full[MAXW-1:W], so_rev_full[MAXW-1:W]};

  // Output is wiring of registers only
  assign so = {so_rev_full[W-1:0], dom};

  // Control FSM, state, remaining-step counter and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st    <= W'(1);
      dom   <= '0;
      fsm   <= IDLE;
      rem   <= '0;
      done  <= 1'b0;
      wrap  <= 1'b0;
      ready <= 1'b1;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (init) begin
            st   <= W'(1);
            dom  <= domain;
            wrap <= 1'b0;
          end else if (load) begin
            st   <= si_rev;
            dom  <= domain;
            wrap <= (si == '0);
          end else if (step) begin
            dom <= domain;
            if (nsteps == '0) begin
              done <= 1'b1;
            end else begin
              rem   <= nsteps;
              fsm   <= RUN;
              ready <= 1'b0;
            end
          end
        end
        RUN: begin
          if (init) begin
            st    <= W'(1);
            wrap  <= 1'b0;
            rem   <= '0;
            fsm   <= IDLE;
            ready <= 1'b1;
          end else begin
            st  <= nxt;
            rem <= rem - CW'(1);
            if (nxt == W'(1)) wrap <= 1'b1;
            if (rem == CW'(1)) begin
              fsm   <= IDLE;
              ready <= 1'b1;
              done  <= 1'b1;
            end
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_gf_counter.sv
// Directed, table-driven bench for lfsr_gf_counter (W=56 main instance, W=24 side instance).
module tb_lfsr_gf_counter;

  localparam logic [1:0] OP_INIT = 2'd0;
  localparam logic [1:0] OP_LOAD = 2'd1;
  localparam logic [1:0] OP_STEP = 2'd2;

  typedef struct {
    logic [1:0]  op;
    logic [55:0] si;
    logic [7:0]  dom;
    logic [7:0]  n;
    logic [63:0] so;
    logic        wrap;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        init, load, step;
  logic [55:0] si;
  logic [7:0]  domain;
  logic [7:0]  nsteps;
  logic [63:0] so;
  logic        ready, done, wrap;

  logic        init2, load2, step2;
  logic [23:0] si2;
  logic [7:0]  domain2;
  logic [7:0]  nsteps2;
  logic [31:0] so2;
  logic        ready2, done2, wrap2;

  int checks;
  int errors;

  lfsr_gf_counter #(.W(56), .POLY(56'h95), .CW(8)) dut (
    .clk(clk), .rst(rst), .init(init), .load(load), .si(si), .domain(domain),
    .step(step), .nsteps(nsteps), .so(so), .ready(ready), .done(done), .wrap(wrap)
  );

  lfsr_gf_counter #(.W(24), .POLY(24'h1B), .CW(8)) dut24 (
    .clk(clk), .rst(rst), .init(init2), .load(load2), .si(si2), .domain(domain2),
    .step(step2), .nsteps(nsteps2), .so(so2), .ready(ready2), .done(done2), .wrap(wrap2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vt[14];

  initial begin
    int k;
    int seen;
    checks = 0;
    errors = 0;

    vt[0]  = '{OP_INIT, 56'h0,               8'h0D, 8'd0, 64'h0100_0000_0000_000D, 1'b0};
    vt[1]  = '{OP_STEP, 56'h0,               8'h0D, 8'd1, 64'h0200_0000_0000_000D, 1'b0};
    vt[2]  = '{OP_INIT, 56'h0,               8'h21, 8'd0, 64'h0100_0000_0000_0021, 1'b0};
    vt[3]  = '{OP_STEP, 56'h0,               8'h22, 8'd8, 64'h0001_0000_0000_0022, 1'b0};
    vt[4]  = '{OP_STEP, 56'h0,               8'h23, 8'd0, 64'h0001_0000_0000_0023, 1'b0};
    vt[5]  = '{OP_LOAD, 56'h00_0000_0000_0080, 8'h44, 8'd0, 64'h0000_0000_0000_8044, 1'b0};
    vt[6]  = '{OP_STEP, 56'h0,               8'h45, 8'd1, 64'h9500_0000_0000_0045, 1'b0};
    vt[7]  = '{OP_STEP, 56'h0,               8'h46, 8'd2, 64'h5402_0000_0000_0046, 1'b0};
    vt[8]  = '{OP_LOAD, 56'h0,               8'h50, 8'd0, 64'h0000_0000_0000_0050, 1'b1};
    vt[9]  = '{OP_STEP, 56'h0,               8'h51, 8'd3, 64'h0000_0000_0000_0051, 1'b1};
    vt[10] = '{OP_INIT, 56'h0,               8'h00, 8'd0, 64'h0100_0000_0000_0000, 1'b0};
    vt[11] = '{OP_LOAD, 56'h4A_0000_0000_0080, 8'h60, 8'd0, 64'h4A00_0000_0000_8060, 1'b0};
    vt[12] = '{OP_STEP, 56'h0,               8'h61, 8'd1, 64'h0100_0000_0000_0061, 1'b1};
    vt[13] = '{OP_STEP, 56'h0,               8'h62, 8'd1, 64'h0200_0000_0000_0062, 1'b1};

    rst = 1'b1;
    init = 0; load = 0; step = 0; si = '0; domain = '0; nsteps = '0;
    init2 = 0; load2 = 0; step2 = 0; si2 = '0; domain2 = '0; nsteps2 = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("reset_so", so, 64'h0100_0000_0000_0000);
    check("reset_ready", 64'(ready), 64'd1);
    check("reset_done", 64'(done), 64'd0);
    check("reset_wrap", 64'(wrap), 64'd0);
    check("reset_so24", 64'(so2), 64'h0100_0000);

    // Table-driven vectors; consecutive steps are issued back-to-back with done
    for (int i = 0; i < 14; i++) begin
      domain = vt[i].dom;
      si     = vt[i].si;
      nsteps = vt[i].n;
      init   = (vt[i].op == OP_INIT);
      load   = (vt[i].op == OP_LOAD);
      step   = (vt[i].op == OP_STEP);
      tick();
      init = 0; load = 0; step = 0;
      if (vt[i].op == OP_STEP) begin
        if (vt[i].n == 8'd0) begin
          check($sformatf("v%0d_done0", i), 64'(done), 64'd1);
          check($sformatf("v%0d_ready0", i), 64'(ready), 64'd1);
        end else begin
          check($sformatf("v%0d_busy", i), 64'(ready), 64'd0);
          k = 0;
          while (!done && k < 300) begin
            tick();
            k++;
          end
          check($sformatf("v%0d_latency", i), 64'(k), 64'(vt[i].n));
          check($sformatf("v%0d_ready", i), 64'(ready), 64'd1);
        end
      end
      check($sformatf("v%0d_so", i), so, vt[i].so);
      check($sformatf("v%0d_wrap", i), 64'(wrap), 64'(vt[i].wrap));
    end

    // done is a single-cycle pulse
    tick();
    check("done_pulse", 64'(done), 64'd0);

    // W=24 instance: MSB feedback through the 24-bit polynomial
    si2 = 24'h000080; domain2 = 8'h5A; load2 = 1;
    tick();
    load2 = 0;
    check("w24_load_so", 64'(so2), 64'h0000_805A);
    step2 = 1; nsteps2 = 8'd1; domain2 = 8'h5B;
    tick();
    step2 = 0;
    check("w24_busy", 64'(ready2), 64'd0);
    tick();
    check("w24_done", 64'(done2), 64'd1);
    check("w24_so", 64'(so2), 64'h1B00_005B);

    // init aborts a long run
    init = 1; domain = 8'h77;
    tick();
    init = 0;
    step = 1; nsteps = 8'd200; domain = 8'h78;
    tick();
    step = 0;
    check("abort_busy", 64'(ready), 64'd0);
    for (int c = 0; c < 4; c++) tick();
    init = 1; domain = 8'h79;
    tick();
    init = 0;
    check("abort_so", so, 64'h0100_0000_0000_0078);
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_done", 64'(done), 64'd0);
    check("abort_wrap", 64'(wrap), 64'd0);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done) seen++;
    end
    check("abort_no_done", 64'(seen), 64'd0);

    // Asynchronous reset in the middle of a run
    step = 1; nsteps = 8'd50; domain = 8'h88;
    tick();
    step = 0;
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    check("rst_async_so", so, 64'h0100_0000_0000_0000);
    check("rst_async_ready", 64'(ready), 64'd1);
    rst = 1'b0;
    tick();
    check("rst_done", 64'(done), 64'd0);
    check("rst_wrap", 64'(wrap), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
